load_size_handler: RTL and testbench

- Load-side counterpart of the store size handler: it fetches one 32-bit memory word and extracts a byte, halfword or word from it.
- Extracted data is sign- or zero-extended to 32 bits.
- Sits between the memory port and the MDR/register-file write path of the multicycle datapath.
- Owns the memory read request and waits out the memory latency, so the control unit issues one start and waits for done.

---
 rtl/load_size_handler.sv | 148 ++++++++++++++
 tb/tb_load_size_handler.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/load_size_handler.sv
// Load size handler: issues one memory read per start, waits MEM_LATENCY cycles,
// then extracts and sign/zero-extends a byte, halfword or word. Optional: MISALIGN_TRAP_EN.
//
// state | meaning
// IDLE  | waiting for start; sel/addr_lo latched on start
// REQ   | mem_rd asserted for one cycle, latency counter loaded
// WAIT  | counting down; capture and extract when counter reaches 1
// DONE  | done pulse, data_out holds the result
// FAULT | (MISALIGN_TRAP_EN only) done+misaligned pulse, no memory access
module load_size_handler #(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        sel,
    input  logic [1:0]        addr_lo,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              done,
    output logic              misaligned
);

    generate
        if (DATA_W != 32) begin : g_bad_width
            $error("load_size_handler: DATA_W must be 32");
        end
        if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
            $error("load_size_handler: MEM_LATENCY must be 1..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
`ifdef MISALIGN_TRAP_EN
        FAULT = 3'd4,
`endif
        DONE  = 3'd3
    } state_t;

    localparam logic [2:0] SEL_LB  = 3'b000;
    localparam logic [2:0] SEL_LH  = 3'b010;
    localparam logic [2:0] SEL_LBU = 3'b011;
    localparam logic [2:0] SEL_LHU = 3'b100;

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [2:0]  sel_q;
    logic [1:0]  addr_q;
    logic        capture;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] extracted;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef MISALIGN_TRAP_EN
                    if (((sel == SEL_LH || sel == SEL_LHU) && addr_lo[0]) ||
                        ((sel == 3'b001 || sel > SEL_LHU) && addr_lo != 2'b00)) begin
                        state_next = FAULT;
                    end else begin
                        state_next = REQ;
                    end
`else
                    state_next = REQ;
`endif
                end
            end
            REQ:  state_next = WAIT;
            WAIT: begin
                if (cnt == 4'd1) begin
                    state_next = DONE;
                end
            end
            DONE: state_next = IDLE;
`ifdef MISALIGN_TRAP_EN
            FAULT: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    assign capture = (state == WAIT) && (cnt == 4'd1);
    assign mem_rd  = (state == REQ);
    assign busy    = (state != IDLE);
`ifdef MISALIGN_TRAP_EN
    assign done       = (state == DONE) || (state == FAULT);
    assign misaligned = (state == FAULT);
`else
    assign done       = (state == DONE);
    assign misaligned = 1'b0;
`endif

    // Lane selection uses the latched offset; upper halfword chosen by addr_q[1] only.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        extracted = mem_data;
        case (addr_q)
            2'd0:    byte_sel = mem_data[7:0];
            2'd1:    byte_sel = mem_data[15:8];
            2'd2:    byte_sel = mem_data[23:16];
            default: byte_sel = mem_data[31:24];
        endcase
        half_sel = addr_q[1] ? mem_data[31:16] : mem_data[15:0];
        case (sel_q)
            SEL_LB:  extracted = {{24{byte_sel[7]}}, byte_sel};
            SEL_LBU: extracted = {24'h000000, byte_sel};
            SEL_LH:  extracted = {{16{half_sel[15]}}, half_sel};
            SEL_LHU: extracted = {16'h0000, half_sel};
            default: extracted = mem_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            sel_q    <= 3'd0;
            addr_q   <= 2'd0;
            data_out <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                sel_q  <= sel;
                addr_q <= addr_lo;
            end
            if (state == REQ) begin
                cnt <= 4'(MEM_LATENCY);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                data_out <= extracted;
            end
        end
    end

endmodule

// File: tb/tb_load_size_handler.sv
// Bench for load_size_handler: two instances (MEM_LATENCY 1 and 3) driven with
// directed and random loads, checked cycle by cycle against an arithmetic reference.
module tb_load_size_handler;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v    [2];
    logic [2:0]  sel_v      [2];
    logic [1:0]  addr_v     [2];
    logic [31:0] mem_data_v [2];
    logic        mem_rd_v   [2];
    logic        busy_v     [2];
    logic        done_v     [2];
    logic        mis_v      [2];
    logic [31:0] data_out_v [2];

    int          vectors     = 0;
    int          miscompares = 0;
    int          lat [2]     = '{1, 3};
    logic [31:0] prev [2];

    always #5 clk = ~clk;

    load_size_handler #(.MEM_LATENCY(1), .DATA_W(32)) u_l1 (
        .clk(clk), .reset(reset), .start(start_v[0]), .sel(sel_v[0]), .addr_lo(addr_v[0]),
        .mem_rd(mem_rd_v[0]), .mem_data(mem_data_v[0]), .data_out(data_out_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .misaligned(mis_v[0])
    );

    load_size_handler #(.MEM_LATENCY(3), .DATA_W(32)) u_l3 (
        .clk(clk), .reset(reset), .start(start_v[1]), .sel(sel_v[1]), .addr_lo(addr_v[1]),
        .mem_rd(mem_rd_v[1]), .mem_data(mem_data_v[1]), .data_out(data_out_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .misaligned(mis_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference extraction from the size/offset rules using plain arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] s, input logic [1:0] a,
                                             input logic [31:0] w);
        int unsigned b;
        int unsigned h;
        b = (w >> (8 * a)) % 256;
        h = (w >> (16 * (a / 2))) % 65536;
        case (s)
            3'd0:    return (b >= 128) ? (32'hFFFFFF00 + b) : b;
            3'd3:    return b;
            3'd2:    return (h >= 32768) ? (32'hFFFF0000 + h) : h;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic bit is_trap(input logic [2:0] s, input logic [1:0] a);
`ifdef MISALIGN_TRAP_EN
        if (s == 3'd2 || s == 3'd4) return (a % 2) == 1;
        if (s == 3'd0 || s == 3'd3) return 1'b0;
        return a != 2'd0;
`else
        return 1'b0;
`endif
    endfunction

    // One load on both instances; window of 6 cycles covers done for latency 3.
    task automatic run_load(input logic [2:0] s, input logic [1:0] a, input logic [31:0] w,
                            input bit force_extra);
        bit          trap;
        logic [31:0] nv;
        trap = is_trap(s, a);
        nv   = trap ? prev[0] : ref_load(s, a, w);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                int    dc;
                string t;
                dc = trap ? 1 : 2 + lat[i];
                t  = $sformatf("L%0d sel=%0d a=%0d c=%0d", lat[i], s, a, c);
                start_v[i]    = (c == 0) || (c <= dc && (force_extra || $urandom_range(0, 1) == 1));
                sel_v[i]      = (c == 0) ? s : 3'($urandom);
                addr_v[i]     = (c == 0) ? a : 2'($urandom);
                mem_data_v[i] = (!trap && c == 1 + lat[i]) ? w : $urandom;
                chk({t, " mem_rd"},     32'(mem_rd_v[i]), 32'(!trap && c == 1));
                chk({t, " done"},       32'(done_v[i]),   32'(c == dc));
                chk({t, " busy"},       32'(busy_v[i]),   32'(c >= 1 && c <= dc));
                chk({t, " misaligned"}, 32'(mis_v[i]),    32'(trap && c == 1));
                chk({t, " data_out"},   data_out_v[i],    (c >= dc) ? nv : prev[i]);
            end
        end
        prev[0] = nv;
        prev[1] = nv;
    endtask

    task automatic reset_in_wait();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            reset = (c == 2);
            for (int i = 0; i < 2; i++) begin
                string t;
                t = $sformatf("rst L%0d c=%0d", lat[i], c);
                start_v[i]    = (c == 0);
                sel_v[i]      = 3'b001;
                addr_v[i]     = 2'b00;
                mem_data_v[i] = 32'hDEADBEEF;
                chk({t, " mem_rd"}, 32'(mem_rd_v[i]), 32'(c == 1));
                chk({t, " busy"},   32'(busy_v[i]),   32'(c == 1 || c == 2));
                chk({t, " done"},   32'(done_v[i]),   32'h0);
                if (c >= 3) chk({t, " data_out"}, data_out_v[i], 32'h0);
            end
        end
        prev[0] = 32'h0;
        prev[1] = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start_v[i]    = 1'b0;
            sel_v[i]      = 3'd0;
            addr_v[i]     = 2'd0;
            mem_data_v[i] = 32'h0;
            prev[i]       = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset L%0d mem_rd", lat[i]),     32'(mem_rd_v[i]), 32'h0);
            chk($sformatf("reset L%0d busy", lat[i]),       32'(busy_v[i]),   32'h0);
            chk($sformatf("reset L%0d done", lat[i]),       32'(done_v[i]),   32'h0);
            chk($sformatf("reset L%0d misaligned", lat[i]), 32'(mis_v[i]),    32'h0);
            chk($sformatf("reset L%0d data_out", lat[i]),   data_out_v[i],    32'h0);
        end
        reset = 1'b0;

        run_load(3'b001, 2'b00, 32'h81F27C03, 1'b0);
        run_load(3'b000, 2'b11, 32'h81F27C03, 1'b0);
        run_load(3'b011, 2'b11, 32'h81F27C03, 1'b0);
        run_load(3'b000, 2'b01, 32'h81F27C03, 1'b0);
        run_load(3'b010, 2'b10, 32'h81F27C03, 1'b0);
        run_load(3'b100, 2'b00, 32'h81F27C03, 1'b0);
        run_load(3'b010, 2'b00, 32'h81F27C03, 1'b0);
        run_load(3'b001, 2'b00, 32'h5A3C9617, 1'b1);
        reset_in_wait();
        run_load(3'b100, 2'b01, 32'h81F27C03, 1'b0);
        for (int n = 0; n < 40; n++) begin
            run_load(3'($urandom), 2'($urandom), $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
